// File: rtl/pifo_reg_ctrl.sv
// Client-side sequencer for one pifo_reg: arbitrates enqueue inserts against
// dequeue removes, presents the min-rank entry as a registered stream and reports drops.
module pifo_reg_ctrl #(
  parameter int L2_REG_WIDTH = 4,
  parameter int RANK_WIDTH   = 16,
  parameter int META_WIDTH   = 12,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [RANK_WIDTH-1:0]   enq_rank,
  input  logic [META_WIDTH-1:0]   enq_meta,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [RANK_WIDTH-1:0]   deq_rank,
  output logic [META_WIDTH-1:0]   deq_meta,
  output logic                    drop_valid,
  output logic [RANK_WIDTH-1:0]   drop_rank,
  output logic [META_WIDTH-1:0]   drop_meta,
  output logic                    pifo_insert,
  output logic [RANK_WIDTH-1:0]   pifo_rank_in,
  output logic [META_WIDTH-1:0]   pifo_meta_in,
  output logic                    pifo_remove,
  input  logic                    pifo_full,
  input  logic                    pifo_valid_out,
  input  logic [RANK_WIDTH-1:0]   pifo_rank_out,
  input  logic [META_WIDTH-1:0]   pifo_meta_out,
  input  logic                    pifo_max_valid,
  input  logic [RANK_WIDTH-1:0]   pifo_max_rank,
  input  logic [META_WIDTH-1:0]   pifo_max_meta,
  input  logic [L2_REG_WIDTH:0]   pifo_num_entries,
  output logic [CNT_WIDTH-1:0]    enq_cnt,
  output logic [CNT_WIDTH-1:0]    deq_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT1, S_WAIT2} state_t;
  typedef enum logic {RR_INSERT, RR_REMOVE} rr_t;

  state_t state;
  rr_t    rr_last;

  logic pifo_empty;
  logic full_no_max;
  logic rem_ok;
  logic ins_ok;
  logic do_ins;
  logic do_rem;
  logic deq_fire;

  // Ops are gated by rst so nothing reaches the shared pifo_reg while it resets.
  always_comb begin
    pifo_empty  = (pifo_num_entries == '0);
    full_no_max = pifo_full & ~pifo_max_valid;
    rem_ok      = ~rst & (state == S_ISSUE) & pifo_valid_out & (~deq_valid | deq_ready);
    ins_ok      = ~rst & (state == S_ISSUE) & enq_valid & (pifo_valid_out | pifo_empty)
                  & ~full_no_max;
    do_ins      = ins_ok & (~rem_ok | (rr_last == RR_REMOVE));
    do_rem      = rem_ok & ~do_ins;
    deq_fire    = deq_valid & deq_ready;
  end

  assign pifo_insert  = do_ins;
  assign pifo_remove  = do_rem;
  assign enq_ready    = do_ins;
  assign pifo_rank_in = enq_rank;
  assign pifo_meta_in = enq_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ISSUE;
      rr_last    <= RR_REMOVE;
      deq_valid  <= 1'b0;
      deq_rank   <= '0;
      deq_meta   <= '0;
      drop_valid <= 1'b0;
      drop_rank  <= '0;
      drop_meta  <= '0;
      enq_cnt    <= '0;
      deq_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      drop_valid <= 1'b0;

      // Two idle cycles after every op let pifo_reg settle its min/max outputs.
      case (state)
        S_ISSUE: if (do_ins || do_rem) state <= S_WAIT1;
        S_WAIT1: state <= S_WAIT2;
        S_WAIT2: state <= S_ISSUE;
        default: state <= S_ISSUE;
      endcase

      if (do_ins) begin
        rr_last <= RR_INSERT;
        enq_cnt <= enq_cnt + CNT_WIDTH'(1);
        if (pifo_full) begin
          drop_valid <= 1'b1;
          drop_cnt   <= drop_cnt + CNT_WIDTH'(1);
          if (enq_rank < pifo_max_rank) begin
            drop_rank <= pifo_max_rank;
            drop_meta <= pifo_max_meta;
          end else begin
            drop_rank <= enq_rank;
            drop_meta <= enq_meta;
          end
        end
      end

      // A remove on the same edge as a handshake reloads the output register.
      if (do_rem) begin
        rr_last   <= RR_REMOVE;
        deq_valid <= 1'b1;
        deq_rank  <= pifo_rank_out;
        deq_meta  <= pifo_meta_out;
      end else if (deq_fire) begin
        deq_valid <= 1'b0;
      end

      if (deq_fire) deq_cnt <= deq_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pifo_reg_ctrl.sv
// Bench for pifo_reg_ctrl with a behavioural pifo_reg and deq/drop scoreboards.
module tb_pifo_reg_ctrl;
  localparam int L2 = 4;
  localparam int RW = 16;
  localparam int MW = 12;
  localparam int CW = 32;
  localparam int DEPTH = 1 << L2;

  logic clk = 1'b0;
  logic rst;
  logic enq_valid, enq_ready, deq_valid, deq_ready, drop_valid;
  logic [RW-1:0] enq_rank, deq_rank, drop_rank, pifo_rank_in, pifo_rank_out, pifo_max_rank;
  logic [MW-1:0] enq_meta, deq_meta, drop_meta, pifo_meta_in, pifo_meta_out, pifo_max_meta;
  logic pifo_insert, pifo_remove, pifo_full, pifo_valid_out, pifo_max_valid;
  logic [L2:0] pifo_num_entries;
  logic [CW-1:0] enq_cnt, deq_cnt, drop_cnt;

  always #5 clk = ~clk;

  pifo_reg_ctrl #(.L2_REG_WIDTH(L2), .RANK_WIDTH(RW), .META_WIDTH(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rank(enq_rank), .enq_meta(enq_meta),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_rank(deq_rank), .deq_meta(deq_meta),
    .drop_valid(drop_valid), .drop_rank(drop_rank), .drop_meta(drop_meta),
    .pifo_insert(pifo_insert), .pifo_rank_in(pifo_rank_in), .pifo_meta_in(pifo_meta_in),
    .pifo_remove(pifo_remove), .pifo_full(pifo_full), .pifo_valid_out(pifo_valid_out),
    .pifo_rank_out(pifo_rank_out), .pifo_meta_out(pifo_meta_out),
    .pifo_max_valid(pifo_max_valid), .pifo_max_rank(pifo_max_rank), .pifo_max_meta(pifo_max_meta),
    .pifo_num_entries(pifo_num_entries),
    .enq_cnt(enq_cnt), .deq_cnt(deq_cnt), .drop_cnt(drop_cnt)
  );

  // Behavioural pifo_reg: sorted storage, min/max outputs registered one cycle behind.
  logic [RW-1:0] m_rank [DEPTH];
  logic [MW-1:0] m_meta [DEPTH];
  int m_cnt = 0;

  assign pifo_full        = (m_cnt == DEPTH);
  assign pifo_num_entries = (L2+1)'(m_cnt);

  always @(posedge clk) begin : pifo_model
    logic [RW-1:0] r [DEPTH];
    logic [MW-1:0] mt [DEPTH];
    int n;
    int p;
    r = m_rank;
    mt = m_meta;
    n = m_cnt;
    if (rst) begin
      n = 0;
    end else begin
      if (pifo_insert) begin
        if (n == DEPTH && pifo_rank_in < r[DEPTH-1]) n = DEPTH - 1;
        if (n < DEPTH) begin
          p = n;
          while (p > 0 && r[p-1] > pifo_rank_in) begin
            r[p] = r[p-1];
            mt[p] = mt[p-1];
            p--;
          end
          r[p] = pifo_rank_in;
          mt[p] = pifo_meta_in;
          n++;
        end
      end
      if (pifo_remove && n > 0) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          r[i] = r[i+1];
          mt[i] = mt[i+1];
        end
        n--;
      end
    end
    if (rst || m_cnt == 0) begin
      pifo_valid_out <= 1'b0;
      pifo_max_valid <= 1'b0;
    end else begin
      pifo_valid_out <= 1'b1;
      pifo_max_valid <= 1'b1;
      pifo_rank_out  <= m_rank[0];
      pifo_meta_out  <= m_meta[0];
      pifo_max_rank  <= m_rank[m_cnt-1];
      pifo_max_meta  <= m_meta[m_cnt-1];
    end
    m_rank <= r;
    m_meta <= mt;
    m_cnt  <= n;
  end

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int last_op = -100;
  logic [RW+MW-1:0] exp_deq [$];
  logic [RW+MW-1:0] exp_drop [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [MW-1:0] meta_of(input logic [RW-1:0] r);
    return r[MW-1:0] ^ 12'h5A5;
  endfunction

  function automatic logic [RW+MW-1:0] ent(input logic [RW-1:0] r);
    return {r, meta_of(r)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Op spacing, mutual exclusion and both scoreboards are checked here.
  always @(negedge clk) begin
    if (rst) begin
      last_op = -100;
    end else begin
      if (pifo_insert || pifo_remove) begin
        check("op_spacing", 64'((cyc - last_op) >= 3), 64'd1);
        check("op_exclusive", 64'(pifo_insert & pifo_remove), 64'd0);
        last_op = cyc;
      end
      if (deq_valid && deq_ready) begin
        check("deq_expected", 64'(exp_deq.size() != 0), 64'd1);
        if (exp_deq.size() != 0) check("deq_entry", 64'({deq_rank, deq_meta}), 64'(exp_deq.pop_front()));
      end
      if (drop_valid) begin
        check("drop_expected", 64'(exp_drop.size() != 0), 64'd1);
        if (exp_drop.size() != 0) check("drop_entry", 64'({drop_rank, drop_meta}), 64'(exp_drop.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [RW-1:0] r);
    logic ok;
    ok = 1'b0;
    enq_rank = r;
    enq_meta = meta_of(r);
    enq_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (enq_ready) ok = 1'b1;
      tick();
    end
    enq_valid = 1'b0;
    check("enq_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    deq_ready = 1'b1;
    for (int k = 0; k < 400 && !done; k++) begin
      if (exp_deq.size() == 0 && !deq_valid) done = 1'b1;
      else tick();
    end
    deq_ready = 1'b0;
    check("drain_done", 64'(done), 64'd1);
  endtask

  initial begin
    logic exp_ins;
    logic got;
    int ops;
    rst = 1'b1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_rank = '0;
    enq_meta = '0;

    // 1: reset state, then insert in the very first cycle out of reset
    repeat (3) tick();
    @(negedge clk);
    check("rst_outputs", 64'({deq_valid, drop_valid, pifo_insert, pifo_remove, enq_ready}), 64'd0);
    check("rst_counters", 64'(enq_cnt | deq_cnt | drop_cnt), 64'd0);
    tick();
    rst = 1'b0;
    enq_rank = 16'd0;
    enq_meta = meta_of(16'd0);
    enq_valid = 1'b1;
    @(negedge clk);
    check("first_insert", 64'({pifo_insert, enq_ready}), 64'b11);
    tick();
    enq_valid = 1'b0;

    // 2: rank 0 is prefetched into the held output; 5,3,9 come out sorted behind it
    enq(16'd5);
    enq(16'd3);
    enq(16'd9);
    exp_deq.push_back(ent(16'd0));
    exp_deq.push_back(ent(16'd3));
    exp_deq.push_back(ent(16'd5));
    exp_deq.push_back(ent(16'd9));
    drain();
    check("t2_enq_cnt", 64'(enq_cnt), 64'd4);
    check("t2_deq_cnt", 64'(deq_cnt), 64'd4);

    // 3: fill the PIFO behind a held entry, then evict and reject
    enq(16'd0);
    for (int i = 1; i <= DEPTH; i++) enq(RW'(i * 10));
    exp_drop.push_back(ent(16'd160));
    enq(16'd1);
    tick();
    check("t3_drop_cnt1", 64'(drop_cnt), 64'd1);
    exp_drop.push_back(ent(16'd200));
    enq(16'd200);
    repeat (2) tick();
    check("t3_drop_cnt2", 64'(drop_cnt), 64'd2);
    check("t3_drop_sb", 64'(exp_drop.size()), 64'd0);

    // 4: backpressure holds the output; release reloads the next min on the same edge
    repeat (6) begin
      @(negedge clk);
      check("t4_hold", 64'({deq_valid, pifo_remove, deq_rank}), 64'({1'b1, 1'b0, 16'd0}));
    end
    exp_deq.push_back(ent(16'd0));
    exp_deq.push_back(ent(16'd1));
    for (int i = 1; i < DEPTH; i++) exp_deq.push_back(ent(RW'(i * 10)));
    tick();
    deq_ready = 1'b1;
    @(negedge clk);
    check("t4_release_remove", 64'(pifo_remove), 64'd1);
    tick();
    check("t4_reload", 64'({deq_valid, deq_rank}), 64'({1'b1, 16'd1}));
    drain();
    check("t4_enq_cnt", 64'(enq_cnt), 64'd23);
    check("t4_deq_cnt", 64'(deq_cnt), 64'd21);

    // 5: continuous enqueue and dequeue alternate strictly, insert first
    deq_ready = 1'b1;
    enq_rank = RW'($urandom_range(0, 1000));
    enq_meta = meta_of(enq_rank);
    enq_valid = 1'b1;
    exp_ins = 1'b1;
    ops = 0;
    for (int k = 0; k < 200 && ops < 12; k++) begin
      @(negedge clk);
      got = 1'b0;
      if (pifo_insert || pifo_remove) begin
        check("t5_alternate", 64'(pifo_insert), 64'(exp_ins));
        exp_ins = ~exp_ins;
        ops++;
        if (pifo_insert) begin
          exp_deq.push_back({enq_rank, enq_meta});
          got = 1'b1;
        end
      end
      tick();
      if (got) begin
        enq_rank = RW'($urandom_range(0, 1000));
        enq_meta = meta_of(enq_rank);
      end
    end
    enq_valid = 1'b0;
    check("t5_ops", 64'(ops), 64'd12);
    drain();
    check("t5_deq_cnt", 64'(deq_cnt), 64'd27);

    // 6: reset while waiting with a held output entry
    enq(16'd7);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (pifo_remove) got = 1'b1;
    end
    check("t6_remove_seen", 64'(got), 64'd1);
    tick();
    check("t6_pre_rst_deq", 64'(deq_valid), 64'd1);
    rst = 1'b1;
    enq_rank = 16'd42;
    enq_meta = meta_of(16'd42);
    enq_valid = 1'b1;
    tick();
    check("t6_rst_state", 64'({deq_valid, drop_valid, pifo_insert}), 64'd0);
    check("t6_rst_counters", 64'(enq_cnt | deq_cnt | drop_cnt), 64'd0);
    exp_deq.delete();
    rst = 1'b0;
    @(negedge clk);
    check("t6_issue_after_rst", 64'(pifo_insert), 64'd1);
    tick();
    enq_valid = 1'b0;
    exp_deq.push_back(ent(16'd42));
    drain();
    check("t6_counts", 64'({enq_cnt, deq_cnt}), 64'({32'd1, 32'd1}));
    check("final_deq_sb", 64'(exp_deq.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
